// File: rtl/tcp_flow_table_pkg.sv
// Shared types for the TCP flow table: the four-tuple key and the insert response.
package tcp_flow_table_pkg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } four_tuple_struct;

    localparam int FOUR_TUPLE_STRUCT_W = $bits(four_tuple_struct);

    // The insert response carries a flowid wide enough for any table size;
    // each table instance uses only its low FLOWID_W bits.
    localparam int FLOWID_MAX_W = 16;

    typedef struct packed {
        logic                    ok;
        logic                    dup;
        logic [FLOWID_MAX_W-1:0] flowid;
    } flow_table_ins_resp_struct;

endpackage

// File: rtl/tcp_flow_table_if.sv
// Request/response bundle between the flow table and its client (RX parser).
interface tcp_flow_table_if #(
    parameter int TAG_W    = tcp_flow_table_pkg::FOUR_TUPLE_STRUCT_W,
    parameter int FLOWID_W = 6
);
    logic                lkup_req_val;
    logic [TAG_W-1:0]    lkup_req_tag;
    logic                lkup_req_rdy;
    logic                lkup_resp_val;
    logic                lkup_resp_hit;
    logic [FLOWID_W-1:0] lkup_resp_flowid;
    logic                lkup_resp_rdy;

    logic                ins_req_val;
    logic [TAG_W-1:0]    ins_req_tag;
    logic                ins_req_rdy;
    logic                ins_resp_val;
    logic                ins_resp_ok;
    logic                ins_resp_dup;
    logic [FLOWID_W-1:0] ins_resp_flowid;
    logic                ins_resp_rdy;

    logic                rem_req_val;
    logic [FLOWID_W-1:0] rem_req_flowid;
    logic                rem_req_rdy;
    logic                rem_miss;

    logic [FLOWID_W:0]   occupancy;

    modport master (
        output lkup_req_val, lkup_req_tag, lkup_resp_rdy,
        output ins_req_val, ins_req_tag, ins_resp_rdy,
        output rem_req_val, rem_req_flowid,
        input  lkup_req_rdy, lkup_resp_val, lkup_resp_hit, lkup_resp_flowid,
        input  ins_req_rdy, ins_resp_val, ins_resp_ok, ins_resp_dup, ins_resp_flowid,
        input  rem_req_rdy, rem_miss, occupancy
    );

    modport slave (
        input  lkup_req_val, lkup_req_tag, lkup_resp_rdy,
        input  ins_req_val, ins_req_tag, ins_resp_rdy,
        input  rem_req_val, rem_req_flowid,
        output lkup_req_rdy, lkup_resp_val, lkup_resp_hit, lkup_resp_flowid,
        output ins_req_rdy, ins_resp_val, ins_resp_ok, ins_resp_dup, ins_resp_flowid,
        output rem_req_rdy, rem_miss, occupancy
    );
endinterface

// File: rtl/tcp_flow_table_alloc.sv
// Free-entry finder: lowest-index clear bit of the valid bitmap, plus a full flag.
module tcp_flow_table_alloc #(
    parameter int FLOW_CNT = 64,
    parameter int FLOWID_W = $clog2(FLOW_CNT)
) (
    input  logic [FLOW_CNT-1:0] valid_i,
    output logic [FLOWID_W-1:0] free_idx_o,
    output logic                full_o
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_idx_o = '0;
        full_o     = 1'b1;
        for (int i = FLOW_CNT - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_idx_o = FLOWID_W'(i);
                full_o     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tcp_flow_table.sv
// Flow lookup table: four-tuple -> flowid with registered lookup, insert with
// duplicate check and lowest-free allocation, and single-cycle remove.
module tcp_flow_table
    import tcp_flow_table_pkg::*;
#(
    parameter int FLOW_CNT = 64,
    parameter int FLOWID_W = $clog2(FLOW_CNT),
    parameter int TAG_W    = FOUR_TUPLE_STRUCT_W
) (
    input  logic           clk,
    input  logic           rst,
    tcp_flow_table_if.slave bus
);

    // Table storage; tags are only meaningful where the valid bit is set.
    logic [FLOW_CNT-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [FLOW_CNT];

    logic                lkup_resp_val_q, lkup_resp_val_d;
    logic                lkup_resp_hit_q, lkup_resp_hit_d;
    logic [FLOWID_W-1:0] lkup_resp_flowid_q, lkup_resp_flowid_d;

    logic                      ins_resp_val_q, ins_resp_val_d;
    flow_table_ins_resp_struct ins_resp_q, ins_resp_d;

    logic                rem_miss_q, rem_miss_d;
    logic [FLOWID_W:0]   occupancy_q, occupancy_d;

    logic [FLOW_CNT-1:0] lkup_match, ins_match, rem_sel;
    logic [FLOWID_W-1:0] lkup_idx, ins_idx, free_idx;
    logic                lkup_hit, ins_hit, rem_valid, full;
    logic                lkup_fire, ins_fire, rem_fire, alloc_we, rem_we;

    // Parallel compares against the start-of-cycle table contents.
    generate
        for (genvar gi = 0; gi < FLOW_CNT; gi++) begin : g_cmp
            assign lkup_match[gi] = valid_q[gi] && (tag_q[gi] == bus.lkup_req_tag);
            assign ins_match[gi]  = valid_q[gi] && (tag_q[gi] == bus.ins_req_tag);
            assign rem_sel[gi]    = (bus.rem_req_flowid == FLOWID_W'(gi));
        end
    endgenerate

    assign lkup_hit = |lkup_match;
    assign ins_hit  = |ins_match;
    // Out-of-range flowids select no entry and therefore read as invalid.
    assign rem_valid = |(rem_sel & valid_q);

    // One-hot to index by OR-ing indices; tags are unique so at most one bit is set.
    always_comb begin
        lkup_idx = '0;
        ins_idx  = '0;
        for (int i = 0; i < FLOW_CNT; i++) begin
            if (lkup_match[i]) lkup_idx = lkup_idx | FLOWID_W'(i);
            if (ins_match[i])  ins_idx  = ins_idx  | FLOWID_W'(i);
        end
    end

    tcp_flow_table_alloc #(
        .FLOW_CNT (FLOW_CNT),
        .FLOWID_W (FLOWID_W)
    ) u_alloc (
        .valid_i    (valid_q),
        .free_idx_o (free_idx),
        .full_o     (full)
    );

    // Handshakes; remove pre-empts insert by withholding ins_req_rdy.
    assign bus.lkup_req_rdy = ~rst & (~lkup_resp_val_q | bus.lkup_resp_rdy);
    assign bus.ins_req_rdy  = ~rst & (~ins_resp_val_q | bus.ins_resp_rdy) & ~bus.rem_req_val;
    assign bus.rem_req_rdy  = ~rst;

    assign lkup_fire = bus.lkup_req_val & bus.lkup_req_rdy;
    assign ins_fire  = bus.ins_req_val  & bus.ins_req_rdy;
    assign rem_fire  = bus.rem_req_val  & bus.rem_req_rdy;
    assign alloc_we  = ins_fire & ~ins_hit & ~full;
    assign rem_we    = rem_fire & rem_valid;

    // Next-state for responses, valid bitmap and occupancy.
    always_comb begin
        lkup_resp_val_d    = lkup_resp_val_q;
        lkup_resp_hit_d    = lkup_resp_hit_q;
        lkup_resp_flowid_d = lkup_resp_flowid_q;
        if (lkup_fire) begin
            lkup_resp_val_d    = 1'b1;
            lkup_resp_hit_d    = lkup_hit;
            lkup_resp_flowid_d = lkup_idx;
        end else if (bus.lkup_resp_rdy) begin
            lkup_resp_val_d = 1'b0;
        end

        ins_resp_val_d = ins_resp_val_q;
        ins_resp_d     = ins_resp_q;
        if (ins_fire) begin
            ins_resp_val_d = 1'b1;
            if (ins_hit) begin
                ins_resp_d.ok     = 1'b0;
                ins_resp_d.dup    = 1'b1;
                ins_resp_d.flowid = FLOWID_MAX_W'(ins_idx);
            end else if (!full) begin
                ins_resp_d.ok     = 1'b1;
                ins_resp_d.dup    = 1'b0;
                ins_resp_d.flowid = FLOWID_MAX_W'(free_idx);
            end else begin
                ins_resp_d.ok     = 1'b0;
                ins_resp_d.dup    = 1'b0;
                ins_resp_d.flowid = '0;
            end
        end else if (bus.ins_resp_rdy) begin
            ins_resp_val_d = 1'b0;
        end

        rem_miss_d = rem_fire & ~rem_valid;

        valid_d = valid_q;
        for (int i = 0; i < FLOW_CNT; i++) begin
            if (alloc_we && (free_idx == FLOWID_W'(i))) valid_d[i] = 1'b1;
            if (rem_we && rem_sel[i])                   valid_d[i] = 1'b0;
        end

        occupancy_d = occupancy_q;
        if (alloc_we && !rem_we)      occupancy_d = occupancy_q + (FLOWID_W+1)'(1);
        else if (rem_we && !alloc_we) occupancy_d = occupancy_q - (FLOWID_W+1)'(1);
    end

    // Control and response state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q            <= '0;
            lkup_resp_val_q    <= 1'b0;
            lkup_resp_hit_q    <= 1'b0;
            lkup_resp_flowid_q <= '0;
            ins_resp_val_q     <= 1'b0;
            ins_resp_q         <= '0;
            rem_miss_q         <= 1'b0;
            occupancy_q        <= '0;
        end else begin
            valid_q            <= valid_d;
            lkup_resp_val_q    <= lkup_resp_val_d;
            lkup_resp_hit_q    <= lkup_resp_hit_d;
            lkup_resp_flowid_q <= lkup_resp_flowid_d;
            ins_resp_val_q     <= ins_resp_val_d;
            ins_resp_q         <= ins_resp_d;
            rem_miss_q         <= rem_miss_d;
            occupancy_q        <= occupancy_d;
        end
    end

    // Tag write on allocation; tags need no reset since valid gates them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FLOW_CNT; i++) begin
            if (alloc_we && (free_idx == FLOWID_W'(i))) tag_q[i] <= bus.ins_req_tag;
        end
    end

    assign bus.lkup_resp_val    = lkup_resp_val_q;
    assign bus.lkup_resp_hit    = lkup_resp_hit_q;
    assign bus.lkup_resp_flowid = lkup_resp_flowid_q;
    assign bus.ins_resp_val     = ins_resp_val_q;
    assign bus.ins_resp_ok      = ins_resp_q.ok;
    assign bus.ins_resp_dup     = ins_resp_q.dup;
    assign bus.ins_resp_flowid  = ins_resp_q.flowid[FLOWID_W-1:0];
    assign bus.rem_miss         = rem_miss_q;
    assign bus.occupancy        = occupancy_q;

endmodule

// File: tb/tb_tcp_flow_table.sv
// Directed bench for tcp_flow_table: a 64-entry table for the main flows and a
// 4-entry table for the full-table cases.
module tb_tcp_flow_table;
    import tcp_flow_table_pkg::*;

    localparam int TW = FOUR_TUPLE_STRUCT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcp_flow_table_if #(.TAG_W(TW), .FLOWID_W(6)) if64 ();
    tcp_flow_table_if #(.TAG_W(TW), .FLOWID_W(2)) if4 ();

    tcp_flow_table #(.FLOW_CNT(64)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));
    tcp_flow_table #(.FLOW_CNT(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

    int checks = 0;
    int passes = 0;

    logic [TW-1:0] tag_a = {32'h0a000001, 32'h0a000002, 16'h1234, 16'h0050};
    logic [TW-1:0] tag_b = {32'h0a000003, 32'h0a000002, 16'h2345, 16'h0050};
    logic [TW-1:0] tag_c = {32'h0a000004, 32'h0a000002, 16'h3456, 16'h01bb};
    logic [TW-1:0] tag_d = {32'h0a000005, 32'h0a000002, 16'h4567, 16'h01bb};
    logic [TW-1:0] tag_e = {32'hc0a80001, 32'hc0a80002, 16'h5678, 16'h0016};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if64.lkup_req_val = 0; if64.lkup_req_tag = '0; if64.lkup_resp_rdy = 1;
        if64.ins_req_val = 0;  if64.ins_req_tag = '0;  if64.ins_resp_rdy = 1;
        if64.rem_req_val = 0;  if64.rem_req_flowid = '0;
        if4.lkup_req_val = 0;  if4.lkup_req_tag = '0;  if4.lkup_resp_rdy = 1;
        if4.ins_req_val = 0;   if4.ins_req_tag = '0;   if4.ins_resp_rdy = 1;
        if4.rem_req_val = 0;   if4.rem_req_flowid = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        checks++; if (if64.lkup_req_rdy !== 1'b0) $display("FAIL rst_lkup_rdy got=%0b exp=0", if64.lkup_req_rdy); else passes++;
        checks++; if (if64.ins_req_rdy !== 1'b0) $display("FAIL rst_ins_rdy got=%0b exp=0", if64.ins_req_rdy); else passes++;
        checks++; if (if64.rem_req_rdy !== 1'b0) $display("FAIL rst_rem_rdy got=%0b exp=0", if64.rem_req_rdy); else passes++;
        checks++; if (if64.lkup_resp_val !== 1'b0 || if64.ins_resp_val !== 1'b0 || if64.rem_miss !== 1'b0)
            $display("FAIL rst_resp got=%0b%0b%0b exp=000", if64.lkup_resp_val, if64.ins_resp_val, if64.rem_miss); else passes++;
        checks++; if (if64.occupancy !== 7'd0) $display("FAIL rst_occ got=%0d exp=0", if64.occupancy); else passes++;
        rst = 0;
        #1;
        checks++; if (if64.lkup_req_rdy !== 1'b1 || if64.rem_req_rdy !== 1'b1)
            $display("FAIL post_rst_rdy got=%0b%0b exp=11", if64.lkup_req_rdy, if64.rem_req_rdy); else passes++;
        $display("reset: done");
    endtask

    task automatic test_lookup_miss();
        if64.lkup_req_val = 1; if64.lkup_req_tag = tag_a;
        tick();
        if64.lkup_req_val = 0;
        checks++; if (if64.lkup_resp_val !== 1'b1) $display("FAIL miss_val got=%0b exp=1", if64.lkup_resp_val); else passes++;
        checks++; if (if64.lkup_resp_hit !== 1'b0) $display("FAIL miss_hit got=%0b exp=0", if64.lkup_resp_hit); else passes++;
        checks++; if (if64.lkup_resp_flowid !== 6'd0) $display("FAIL miss_flowid got=%0d exp=0", if64.lkup_resp_flowid); else passes++;
        checks++; if (if64.occupancy !== 7'd0) $display("FAIL miss_occ got=%0d exp=0", if64.occupancy); else passes++;
        tick();
        checks++; if (if64.lkup_resp_val !== 1'b0) $display("FAIL miss_drain got=%0b exp=0", if64.lkup_resp_val); else passes++;
        $display("lookup A: hit=0 flowid=0");
    endtask

    task automatic test_insert_abc();
        logic [TW-1:0] tags [3];
        tags[0] = tag_a; tags[1] = tag_b; tags[2] = tag_c;
        for (int i = 0; i < 3; i++) begin
            if64.ins_req_val = 1; if64.ins_req_tag = tags[i];
            tick();
            checks++; if (if64.ins_resp_val !== 1'b1 || if64.ins_resp_ok !== 1'b1 || if64.ins_resp_dup !== 1'b0 || if64.ins_resp_flowid !== 6'(i))
                $display("FAIL ins_abc_%0d got val=%0b ok=%0b dup=%0b id=%0d exp val=1 ok=1 dup=0 id=%0d",
                         i, if64.ins_resp_val, if64.ins_resp_ok, if64.ins_resp_dup, if64.ins_resp_flowid, i); else passes++;
            $display("insert %0d: ok=%0b flowid=%0d", i, if64.ins_resp_ok, if64.ins_resp_flowid);
        end
        if64.ins_req_val = 0;
        if64.lkup_req_val = 1; if64.lkup_req_tag = tag_b;
        tick();
        if64.lkup_req_val = 0;
        checks++; if (if64.lkup_resp_hit !== 1'b1 || if64.lkup_resp_flowid !== 6'd1)
            $display("FAIL lkup_b got hit=%0b id=%0d exp hit=1 id=1", if64.lkup_resp_hit, if64.lkup_resp_flowid); else passes++;
        checks++; if (if64.occupancy !== 7'd3) $display("FAIL occ_abc got=%0d exp=3", if64.occupancy); else passes++;
        $display("lookup B: hit=%0b flowid=%0d", if64.lkup_resp_hit, if64.lkup_resp_flowid);
    endtask

    task automatic test_dup();
        if64.ins_req_val = 1; if64.ins_req_tag = tag_a;
        tick();
        if64.ins_req_val = 0;
        checks++; if (if64.ins_resp_dup !== 1'b1 || if64.ins_resp_ok !== 1'b0 || if64.ins_resp_flowid !== 6'd0)
            $display("FAIL dup_a got dup=%0b ok=%0b id=%0d exp dup=1 ok=0 id=0", if64.ins_resp_dup, if64.ins_resp_ok, if64.ins_resp_flowid); else passes++;
        tick();
        checks++; if (if64.occupancy !== 7'd3) $display("FAIL dup_occ got=%0d exp=3", if64.occupancy); else passes++;
        $display("insert A again: dup=1 flowid=0");
    endtask

    task automatic test_remove_insert();
        if64.rem_req_val = 1; if64.rem_req_flowid = 6'd1;
        if64.ins_req_val = 1; if64.ins_req_tag = tag_d;
        #1;
        checks++; if (if64.ins_req_rdy !== 1'b0) $display("FAIL rem_stalls_ins got=%0b exp=0", if64.ins_req_rdy); else passes++;
        tick();
        if64.rem_req_val = 0;
        checks++; if (if64.ins_resp_val !== 1'b0) $display("FAIL stalled_no_resp got=%0b exp=0", if64.ins_resp_val); else passes++;
        checks++; if (if64.occupancy !== 7'd2) $display("FAIL rem1_occ got=%0d exp=2", if64.occupancy); else passes++;
        tick();
        if64.ins_req_val = 0;
        checks++; if (if64.ins_resp_ok !== 1'b1 || if64.ins_resp_flowid !== 6'd1)
            $display("FAIL ins_d got ok=%0b id=%0d exp ok=1 id=1", if64.ins_resp_ok, if64.ins_resp_flowid); else passes++;
        checks++; if (if64.occupancy !== 7'd3) $display("FAIL ins_d_occ got=%0d exp=3", if64.occupancy); else passes++;
        $display("remove 1 / insert D: flowid=%0d", if64.ins_resp_flowid);
        if64.lkup_req_val = 1; if64.lkup_req_tag = tag_b;
        tick();
        if64.lkup_req_val = 0;
        checks++; if (if64.lkup_resp_hit !== 1'b0) $display("FAIL lkup_b_gone got=%0b exp=0", if64.lkup_resp_hit); else passes++;
        if64.rem_req_val = 1; if64.rem_req_flowid = 6'd1;
        tick();
        if64.rem_req_val = 0;
        checks++; if (if64.rem_miss !== 1'b0 || if64.occupancy !== 7'd2)
            $display("FAIL rem1_again got miss=%0b occ=%0d exp miss=0 occ=2", if64.rem_miss, if64.occupancy); else passes++;
        if64.rem_req_val = 1; if64.rem_req_flowid = 6'd5;
        tick();
        if64.rem_req_val = 0;
        checks++; if (if64.rem_miss !== 1'b1 || if64.occupancy !== 7'd2)
            $display("FAIL rem5_miss got miss=%0b occ=%0d exp miss=1 occ=2", if64.rem_miss, if64.occupancy); else passes++;
        tick();
        checks++; if (if64.rem_miss !== 1'b0) $display("FAIL rem_miss_pulse got=%0b exp=0", if64.rem_miss); else passes++;
        $display("remove 5: rem_miss pulsed");
    endtask

    task automatic test_back_to_back();
        if64.ins_req_val = 1; if64.ins_req_tag = tag_e;
        if64.lkup_req_val = 1; if64.lkup_req_tag = tag_e;
        tick();
        if64.lkup_req_val = 0;
        checks++; if (if64.lkup_resp_hit !== 1'b0) $display("FAIL lkup_vs_ins got=%0b exp=0", if64.lkup_resp_hit); else passes++;
        checks++; if (if64.ins_resp_ok !== 1'b1 || if64.ins_resp_flowid !== 6'd1)
            $display("FAIL ins_e got ok=%0b id=%0d exp ok=1 id=1", if64.ins_resp_ok, if64.ins_resp_flowid); else passes++;
        tick();
        if64.ins_req_val = 0;
        checks++; if (if64.ins_resp_dup !== 1'b1 || if64.ins_resp_ok !== 1'b0 || if64.ins_resp_flowid !== 6'd1)
            $display("FAIL b2b_dup got dup=%0b ok=%0b id=%0d exp dup=1 ok=0 id=1", if64.ins_resp_dup, if64.ins_resp_ok, if64.ins_resp_flowid); else passes++;
        checks++; if (if64.occupancy !== 7'd3) $display("FAIL b2b_occ got=%0d exp=3", if64.occupancy); else passes++;
        $display("back-to-back insert E: second returns dup");
        if64.lkup_req_val = 1; if64.lkup_req_tag = tag_a;
        if64.rem_req_val = 1;  if64.rem_req_flowid = 6'd0;
        tick();
        if64.lkup_req_val = 0; if64.rem_req_val = 0;
        checks++; if (if64.lkup_resp_hit !== 1'b1 || if64.lkup_resp_flowid !== 6'd0)
            $display("FAIL lkup_vs_rem got hit=%0b id=%0d exp hit=1 id=0", if64.lkup_resp_hit, if64.lkup_resp_flowid); else passes++;
        checks++; if (if64.occupancy !== 7'd2) $display("FAIL rem0_occ got=%0d exp=2", if64.occupancy); else passes++;
        $display("lookup A with remove 0: old hit returned");
    endtask

    task automatic test_full();
        logic [TW-1:0] t;
        for (int i = 0; i < 4; i++) begin
            t = tag_a + TW'(i + 100);
            if4.ins_req_val = 1; if4.ins_req_tag = t;
            tick();
            checks++; if (if4.ins_resp_ok !== 1'b1 || if4.ins_resp_flowid !== 2'(i))
                $display("FAIL fill_%0d got ok=%0b id=%0d exp ok=1 id=%0d", i, if4.ins_resp_ok, if4.ins_resp_flowid, i); else passes++;
        end
        if4.ins_req_tag = tag_a + TW'(200);
        tick();
        if4.ins_req_val = 0;
        checks++; if (if4.ins_resp_ok !== 1'b0 || if4.ins_resp_dup !== 1'b0 || if4.ins_resp_flowid !== 2'd0)
            $display("FAIL full_ins got ok=%0b dup=%0b id=%0d exp ok=0 dup=0 id=0", if4.ins_resp_ok, if4.ins_resp_dup, if4.ins_resp_flowid); else passes++;
        checks++; if (if4.occupancy !== 3'd4) $display("FAIL full_occ got=%0d exp=4", if4.occupancy); else passes++;
        $display("full table: 5th insert rejected");
        if4.rem_req_val = 1; if4.rem_req_flowid = 2'd2;
        tick();
        if4.rem_req_val = 0;
        checks++; if (if4.occupancy !== 3'd3) $display("FAIL full_rem_occ got=%0d exp=3", if4.occupancy); else passes++;
        if4.ins_req_val = 1;
        tick();
        if4.ins_req_val = 0;
        checks++; if (if4.ins_resp_ok !== 1'b1 || if4.ins_resp_flowid !== 2'd2 || if4.occupancy !== 3'd4)
            $display("FAIL refill got ok=%0b id=%0d occ=%0d exp ok=1 id=2 occ=4", if4.ins_resp_ok, if4.ins_resp_flowid, if4.occupancy); else passes++;
        $display("remove 2 then insert: flowid=%0d", if4.ins_resp_flowid);
    endtask

    task automatic test_lookup_hold();
        if64.lkup_resp_rdy = 0;
        if64.lkup_req_val = 1; if64.lkup_req_tag = tag_c;
        tick();
        if64.lkup_req_tag = tag_e;
        for (int i = 0; i < 3; i++) begin
            checks++; if (if64.lkup_req_rdy !== 1'b0) $display("FAIL hold_rdy_%0d got=%0b exp=0", i, if64.lkup_req_rdy); else passes++;
            tick();
            checks++; if (if64.lkup_resp_val !== 1'b1 || if64.lkup_resp_hit !== 1'b1 || if64.lkup_resp_flowid !== 6'd2)
                $display("FAIL hold_stable_%0d got val=%0b hit=%0b id=%0d exp val=1 hit=1 id=2",
                         i, if64.lkup_resp_val, if64.lkup_resp_hit, if64.lkup_resp_flowid); else passes++;
        end
        rst = 1;
        tick();
        checks++; if (if64.lkup_resp_val !== 1'b0 || if64.occupancy !== 7'd0)
            $display("FAIL hold_rst got val=%0b occ=%0d exp val=0 occ=0", if64.lkup_resp_val, if64.occupancy); else passes++;
        rst = 0;
        if64.lkup_resp_rdy = 1;
        if64.lkup_req_tag = tag_c;
        tick();
        if64.lkup_req_val = 0;
        checks++; if (if64.lkup_resp_val !== 1'b1 || if64.lkup_resp_hit !== 1'b0)
            $display("FAIL post_rst_lkup got val=%0b hit=%0b exp val=1 hit=0", if64.lkup_resp_val, if64.lkup_resp_hit); else passes++;
        $display("held lookup dropped by reset; table empty");
    endtask

    initial begin
        idle_all();
        test_reset();
        test_lookup_miss();
        test_insert_abc();
        test_dup();
        test_remove_insert();
        test_back_to_back();
        test_full();
        test_lookup_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
